lsu_rmw: RTL and testbench

- Load/store unit between the CPU execute stage and the word-wide data memory `dmem32`.
- Converts byte, halfword and word loads/stores into word-aligned memory accesses.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Drives dmem32's addr/writeData/memWrite and consumes its readData.

---
 rtl/lsu_rmw.sv | 194 +++++++++++++++++++
 tb/tb_lsu_rmw.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit in front of the word-wide dmem32: aligns accesses, sign/zero-extends
// sub-word loads and performs read-modify-write for byte/half stores.
module lsu_rmw #(
  parameter int RD_LAT          = 1,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    MERGE = 3'd3,
    WRITE = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t      stateR;
  logic        writeR;
  logic [1:0]  sizeR;
  logic        unsR;
  logic [1:0]  addrLoR;
  logic [31:0] wdataR;
  logic [31:0] wordR;
  logic [1:0]  waitCntR;
  logic        errS;

  function automatic logic [31:0] extractLane(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeLane(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00: begin
        case (lo)
          2'd0:    r = {w[31:8], d[7:0]};
          2'd1:    r = {w[31:16], d[7:0], w[7:0]};
          2'd2:    r = {w[31:24], d[7:0], w[15:0]};
          2'd3:    r = {d[7:0], w[23:0]};
          default: r = w;
        endcase
      end
      2'b01:   r = lo[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request error classification: illegal size always, misalignment only when enabled
  always_comb begin
    errS = 1'b0;
    if (req_size == 2'b11) begin
      errS = 1'b1;
    end else if (ERR_ON_MISALIGN) begin
      errS = ((req_size == 2'b01) && req_addr[0]) ||
             ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    end else begin
      errS = 1'b0;
    end
  end

  // Sequencer with registered outputs; loads use the MERGE slot to extract their lane
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateR         <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_addr       <= 32'd0;
      mem_write      <= 1'b0;
      mem_write_data <= 32'd0;
      writeR         <= 1'b0;
      sizeR          <= 2'b00;
      unsR           <= 1'b0;
      addrLoR        <= 2'b00;
      wdataR         <= 32'd0;
      wordR          <= 32'd0;
      waitCntR       <= 2'd0;
    end else begin
      case (stateR)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            writeR    <= req_write;
            sizeR     <= req_size;
            unsR      <= req_unsigned;
            addrLoR   <= req_addr[1:0];
            wdataR    <= req_wdata;
            if (errS) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              stateR     <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_write && (req_size == 2'b10)) begin
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
                stateR         <= WRITE;
              end else begin
                stateR <= READ;
              end
            end
          end
        end
        READ: begin
          waitCntR <= 2'd0;
          stateR   <= WAIT;
        end
        WAIT: begin
          if (waitCntR == WAIT_LAST) begin
            wordR  <= mem_read_data;
            stateR <= MERGE;
          end else begin
            waitCntR <= waitCntR + 2'd1;
          end
        end
        MERGE: begin
          if (writeR) begin
            mem_write      <= 1'b1;
            mem_write_data <= mergeLane(wordR, sizeR, addrLoR, wdataR);
            stateR         <= WRITE;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extractLane(wordR, sizeR, addrLoR, unsR);
            stateR     <= RESP;
          end
        end
        WRITE: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          stateR     <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          stateR     <= IDLE;
        end
        default: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          stateR     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw against a small behavioural dmem32 (one-cycle registered read).
module tb_lsu_rmw;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        pokeEn;
  logic [5:0]  pokeIdx;
  logic [31:0] pokeData;
  int          writeCount;
  logic [31:0] lastWAddr;
  logic [31:0] lastWData;

  int nChecks;
  int nFails;

  lsu_rmw #(.RD_LAT(1), .ERR_ON_MISALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // dmem32 model: synchronous write, registered read, plus a bench-side preload port
  always @(posedge clock) begin
    if (pokeEn) mem[pokeIdx] <= pokeData;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[7:2]];
  end

  always @(posedge clock) begin
    if (mem_write) begin
      writeCount <= writeCount + 1;
      lastWAddr  <= mem_addr;
      lastWData  <= mem_write_data;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    pokeEn = 1'b1; pokeIdx = addr[7:2]; pokeData = data;
    @(negedge clock);
    pokeEn = 1'b0;
  endtask

  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
    logic seen;
    seen = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
    @(posedge clock);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        seen = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    checkVal("resp_seen", {31'd0, seen}, 32'd1);
    @(negedge clock);
    checkVal("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
    checkVal("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          wc0;
    int          cyc;
    int          respCyc;
    int          readyCyc;
    logic        sawResp;

    nChecks = 0; nFails = 0; writeCount = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    pokeEn = 1'b0; pokeIdx = 6'd0; pokeData = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    checkVal("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkVal("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkVal("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkVal("rst_resp_rdata", resp_rdata, 32'd0);
    checkVal("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkVal("rst_mem_addr", mem_addr, 32'd0);
    checkVal("rst_mem_wdata", mem_write_data, 32'd0);

    // Word load
    poke(32'h10, 32'hA000_0000);
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, rd, er);
    checkVal("lw_lat", lat, 32'd4);
    checkVal("lw_data", rd, 32'hA000_0000);
    checkVal("lw_err", {31'd0, er}, 32'd0);

    // Byte store with read-modify-write
    wc0 = writeCount;
    doReq(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00F5, lat, rd, er);
    checkVal("sb_lat", lat, 32'd5);
    checkVal("sb_rdata", rd, 32'd0);
    checkVal("sb_err", {31'd0, er}, 32'd0);
    checkVal("sb_write_count", writeCount - wc0, 32'd1);
    checkVal("sb_write_addr", lastWAddr, 32'h10);
    checkVal("sb_write_data", lastWData, 32'hF500_0000);
    checkVal("sb_mem", mem[4], 32'hF500_0000);

    doReq(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, lat, rd, er);
    checkVal("lb_signed", rd, 32'hFFFF_FFF5);
    checkVal("lb_lat", lat, 32'd4);
    doReq(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, lat, rd, er);
    checkVal("lbu", rd, 32'h0000_00F5);

    // Half store into upper lane, then lane extraction checks
    poke(32'h10, 32'h1122_3344);
    doReq(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, lat, rd, er);
    checkVal("sh_lat", lat, 32'd5);
    checkVal("sh_mem", mem[4], 32'h1234_3344);
    doReq(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, lat, rd, er);
    checkVal("lh_low", rd, 32'h0000_3344);
    doReq(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, lat, rd, er);
    checkVal("lh_high", rd, 32'h0000_1234);
    doReq(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, lat, rd, er);
    checkVal("lb_lane1", rd, 32'h0000_0033);

    // Error responses: no memory traffic
    wc0 = writeCount;
    doReq(1'b0, 2'b10, 1'b0, 32'h11, 32'd0, lat, rd, er);
    checkVal("mis_lw_lat", lat, 32'd1);
    checkVal("mis_lw_err", {31'd0, er}, 32'd1);
    checkVal("mis_lw_rdata", rd, 32'd0);
    doReq(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, lat, rd, er);
    checkVal("size11_lat", lat, 32'd1);
    checkVal("size11_err", {31'd0, er}, 32'd1);
    doReq(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_ABCD, lat, rd, er);
    checkVal("mis_sh_err", {31'd0, er}, 32'd1);
    checkVal("err_no_write", writeCount - wc0, 32'd0);
    checkVal("err_mem_kept", mem[4], 32'h1234_3344);

    // Back-to-back: store word with the following load held on req_valid
    wc0 = writeCount;
    respCyc = 0; readyCyc = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clock);
    #1 req_write = 1'b0; req_wdata = 32'd0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      if (resp_valid) begin
        respCyc = cyc;
        checkVal("b2b_ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
      if (req_ready) begin
        readyCyc = cyc;
        break;
      end
    end
    checkVal("b2b_store_lat", respCyc, 32'd2);
    checkVal("b2b_ready_cycle", readyCyc, 32'd3);
    @(posedge clock);
    #1 req_valid = 1'b0;
    sawResp = 1'b0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        sawResp = 1'b1; lat = i; rd = resp_rdata;
        break;
      end
    end
    checkVal("b2b_load_seen", {31'd0, sawResp}, 32'd1);
    checkVal("b2b_load_lat", lat, 32'd4);
    checkVal("b2b_load_data", rd, 32'hDEAD_BEEF);
    checkVal("b2b_one_write", writeCount - wc0, 32'd1);
    repeat (2) @(negedge clock);

    // Reset during WAIT of a byte store
    poke(32'h30, 32'h5566_7788);
    wc0 = writeCount;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h0000_00AA;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkVal("rst_mid_mem_write", {31'd0, mem_write}, 32'd0);
    checkVal("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sawResp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (resp_valid) sawResp = 1'b1;
    end
    checkVal("rst_mid_no_resp", {31'd0, sawResp}, 32'd0);
    checkVal("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    checkVal("rst_mid_no_write", writeCount - wc0, 32'd0);
    checkVal("rst_mid_mem_kept", mem[12], 32'h5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
